// File: rtl/mxrv_div_pkg.sv
// Shared definitions for the RV32M multi-cycle divider: funct3 codes, bus widths
// and FSM state encoding.
package mxrv_div_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [XLEN_DEF-1:0] reg_bus_t;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/mxrv_div_if.sv
// EX-stage <-> divider interface. EX is the master; the divider is the slave.
interface mxrv_div_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start_i;
  logic [2:0]            funct3_i;
  logic [XLEN-1:0]       dividend_i;
  logic [XLEN-1:0]       divisor_i;
  logic [REG_ADDR_W-1:0] rd_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  result_valid_o;
  logic [XLEN-1:0]       result_o;
  logic [REG_ADDR_W-1:0] rd_o;

  modport master (
    output start_i, funct3_i, dividend_i, divisor_i, rd_i, flush_i,
    input  busy_o, result_valid_o, result_o, rd_o
  );

  modport slave (
    input  start_i, funct3_i, dividend_i, divisor_i, rd_i, flush_i,
    output busy_o, result_valid_o, result_o, rd_o
  );
endinterface

// File: rtl/mxrv_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved in IDLE without iterating.
module mxrv_div
  import mxrv_div_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  mxrv_div_if.slave   div_if
);

  div_state_t            r_state;
  logic [2:0]            r_op;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_a_neg;
  logic                  r_b_neg;
  logic [XLEN-1:0]       r_div;
  logic [XLEN-1:0]       r_rem;
  logic [XLEN-1:0]       r_quot;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_valid;
  logic [XLEN-1:0]       r_result;
  logic [REG_ADDR_W-1:0] r_rd_out;

  // Request decode and operand conditioning
  logic            w_signed, w_is_rem, w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [XLEN-1:0] w_a_abs, w_b_abs, w_spec_res;

  assign w_signed = ~div_if.funct3_i[0];
  assign w_is_rem = div_if.funct3_i[1];
  assign w_a_neg  = w_signed & div_if.dividend_i[XLEN-1];
  assign w_b_neg  = w_signed & div_if.divisor_i[XLEN-1];
  assign w_a_abs  = w_a_neg ? -div_if.dividend_i : div_if.dividend_i;
  assign w_b_abs  = w_b_neg ? -div_if.divisor_i  : div_if.divisor_i;
  assign w_div0   = (div_if.divisor_i == '0);
  assign w_ovf    = w_signed &&
                    (div_if.dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (div_if.divisor_i == '1);

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = w_is_rem ? div_if.dividend_i : '1;
    else if (w_ovf)
      w_spec_res = w_is_rem ? '0 : div_if.dividend_i;
  end

  // One restoring step; trial is XLEN+1 bits so its MSB is the borrow
  logic [XLEN:0]   w_rem_sh, w_trial;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx, w_quot_nx, w_fix_q, w_fix_r, w_calc_res;
  logic            w_last;

  assign w_rem_sh   = {r_rem, r_quot[XLEN-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_div};
  assign w_ge       = ~w_trial[XLEN];
  assign w_rem_nx   = w_ge ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quot_nx  = {r_quot[XLEN-2:0], w_ge};
  assign w_last     = (r_cnt == CNT_W'(XLEN-1));

  assign w_fix_q    = ((r_op == INST_DIV) && (r_a_neg ^ r_b_neg)) ? -w_quot_nx : w_quot_nx;
  assign w_fix_r    = ((r_op == INST_REM) && r_a_neg) ? -w_rem_nx : w_rem_nx;
  assign w_calc_res = r_op[1] ? w_fix_r : w_fix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_div    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (div_if.start_i && !div_if.flush_i) begin
            r_op    <= div_if.funct3_i;
            r_rd    <= div_if.rd_i;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_div   <= w_b_abs;
            r_busy  <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_state  <= S_DONE;
              r_result <= w_spec_res;
              r_rd_out <= div_if.rd_i;
              r_valid  <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= '0;
              r_rem   <= '0;
              r_quot  <= w_a_abs;
            end
          end
        end
        S_CALC: begin
          if (div_if.flush_i) begin
            // Flush on the final iteration also drops the pending pulse
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rem  <= w_rem_nx;
            r_quot <= w_quot_nx;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state  <= S_DONE;
              r_result <= w_calc_res;
              r_rd_out <= r_rd;
              r_valid  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign div_if.busy_o         = r_busy;
  assign div_if.result_valid_o = r_valid;
  assign div_if.result_o       = r_result;
  assign div_if.rd_o           = r_rd_out;

endmodule
